// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: word width and register-file geometry.
package cpu_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/reg_read_port.sv
// One combinational register-file read port: storage mux, write-first bypass and
// zero-forcing of register 0 and of every read while reset is held.
module reg_read_port
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH  = WORD_W,
    parameter int unsigned DEPTH  = NUM_REGS,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic                         rst,
    input  logic [DEPTH-1:0][WIDTH-1:0]  storage,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            waddr,
    input  logic [WIDTH-1:0]             wdata,
    input  logic [ADDR_W-1:0]            raddr,
    output logic [WIDTH-1:0]             rdata
);

    logic bypass_hit;

    assign bypass_hit = we && (raddr == waddr);

    // Zero-force outranks the bypass so a write aimed at r0 never leaks out.
    always_comb begin
        rdata = '0;
        if (rst || (raddr == '0)) begin
            rdata = '0;
        end else if (bypass_hit) begin
            rdata = wdata;
        end else begin
            rdata = storage[raddr];
        end
    end

endmodule

// File: rtl/reg_file.sv
// Register file for the single-cycle datapath: two combinational read ports with
// write-first bypass and one synchronous write port; r0 reads as zero.
module reg_file
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH  = WORD_W,
    parameter int unsigned DEPTH  = NUM_REGS,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic                        wr_en;

    // Entry 0 is cleared by reset and never written, so it stays zero.
    assign wr_en = we && (waddr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
        end else if (wr_en) begin
            mem_q[waddr] <= wdata;
        end
    end

    reg_read_port #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_port_a (
        .rst     (rst),
        .storage (mem_q),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr   (raddr_a),
        .rdata   (rdata_a)
    );

    reg_read_port #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_port_b (
        .rst     (rst),
        .storage (mem_q),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr   (raddr_b),
        .rdata   (rdata_b)
    );

endmodule
